sdram_tile_dma: RTL and testbench

- Sequencing stage directly upstream of the single-word SDRAM access FSM (start_read/start_write/addr/data_in in, data_out/done back).
- Turns one command (direction, base address, word count) into a run of single-word SDRAM accesses.
- Read: streams fetched words to the systolic-array tile buffers over valid/ready.
- Write: drains result words from the array into consecutive SDRAM addresses.

---
 rtl/sdram_pkg.sv | 22 ++
 rtl/sdram_tile_dma_if.sv | 34 +++
 rtl/sdram_tile_dma.sv | 182 ++++++++++++++++++
 tb/tb_sdram_tile_dma.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Definitions shared between the SDRAM access FSM and the tile DMA sequencer
// that sits in front of it.
//   SDRAM_ADDR_WIDTH / SDRAM_DATA_WIDTH : default word-address and word widths
//   dma_state_t                         : sequencer states
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam int SDRAM_ADDR_WIDTH = 24;
    localparam int SDRAM_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_FILL,
        DMA_ISSUE,
        DMA_WAIT,
        DMA_DRAIN,
        DMA_FINISH
    } dma_state_t;

endpackage

// File: rtl/sdram_tile_dma_if.sv
// -----------------------------------------------------------------------------
// sdram_tile_dma_if
// Single-word request/response bus between the tile DMA (master) and the
// SDRAM access FSM (slave).
//   mem_start_read / mem_start_write : one-cycle start strobes  (master -> slave)
//   mem_addr / mem_data_in           : word address, write word (master -> slave)
//   mem_data_out                     : read word                (slave -> master)
//   mem_done                         : access-complete pulse    (slave -> master)
// -----------------------------------------------------------------------------
interface sdram_tile_dma_if
    import sdram_pkg::*;
#(
    parameter int ADDR_WIDTH = SDRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SDRAM_DATA_WIDTH
);

    logic                  mem_start_read;
    logic                  mem_start_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_done;

    modport master (
        output mem_start_read, mem_start_write, mem_addr, mem_data_in,
        input  mem_data_out, mem_done
    );

    modport slave (
        input  mem_start_read, mem_start_write, mem_addr, mem_data_in,
        output mem_data_out, mem_done
    );

endinterface

// File: rtl/sdram_tile_dma.sv
// -----------------------------------------------------------------------------
// sdram_tile_dma
// Turns one command (direction, base word address, word count) into a run of
// single-word accesses on the SDRAM access FSM. Reads stream fetched words out
// over rd_valid/rd_ready; writes drain words arriving on wr_valid/wr_ready
// into consecutive addresses. One word is in flight at a time.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake (ready only when idle)
//   cmd_write/addr/len    : direction (1 = stream->SDRAM), base, word count
//   busy, xfer_done       : not idle / one-cycle end-of-command pulse
//   rd_data/valid/ready   : read stream to the tile buffers
//   wr_data/valid/ready   : write stream from the array
//   mem                   : master side of the access-FSM bus
//   xfer_checksum         : modulo-2^DATA_WIDTH sum of the transferred words,
//                           present only when SDRAM_TILE_DMA_CHECKSUM_EN is set
//
// All outputs are registers or decodes of the state register, so there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module sdram_tile_dma
    import sdram_pkg::*;
#(
    parameter int ADDR_WIDTH = SDRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SDRAM_DATA_WIDTH,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  busy,
    output logic                  xfer_done,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
`ifdef SDRAM_TILE_DMA_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] xfer_checksum,
`endif
    sdram_tile_dma_if.master      mem
);

    dma_state_t            state, state_nxt;
    logic                  is_write;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [DATA_WIDTH-1:0] rd_word_q;
    logic [DATA_WIDTH-1:0] wr_word_q;
    logic                  last_word;

    assign last_word       = (remaining == LEN_WIDTH'(1));
    assign mem.mem_addr    = cur_addr;
    assign mem.mem_data_in = wr_word_q;
    assign rd_data         = rd_word_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DMA_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt           = state;
        cmd_ready           = 1'b0;
        busy                = 1'b1;
        xfer_done           = 1'b0;
        rd_valid            = 1'b0;
        wr_ready            = 1'b0;
        mem.mem_start_read  = 1'b0;
        mem.mem_start_write = 1'b0;

        case (state)
            DMA_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_len == '0)  state_nxt = DMA_FINISH;
                    else if (cmd_write) state_nxt = DMA_FILL;
                    else                state_nxt = DMA_ISSUE;
                end
            end
            DMA_FILL: begin
                wr_ready = 1'b1;
                if (wr_valid) state_nxt = DMA_ISSUE;
            end
            DMA_ISSUE: begin
                mem.mem_start_write = is_write;
                mem.mem_start_read  = !is_write;
                state_nxt           = DMA_WAIT;
            end
            DMA_WAIT: begin
                if (mem.mem_done) begin
                    if (!is_write)      state_nxt = DMA_DRAIN;
                    else if (last_word) state_nxt = DMA_FINISH;
                    else                state_nxt = DMA_FILL;
                end
            end
            DMA_DRAIN: begin
                rd_valid = 1'b1;
                if (rd_ready) state_nxt = last_word ? DMA_FINISH : DMA_ISSUE;
            end
            DMA_FINISH: begin
                xfer_done = 1'b1;
                state_nxt = DMA_IDLE;
            end
            default: state_nxt = DMA_IDLE;
        endcase
    end

    // Datapath. The address advances once per completed word: after mem_done
    // for writes, after the stream accepts the word for reads. Wrap past the
    // top of the address space is plain modulo arithmetic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write  <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
            rd_word_q <= '0;
            wr_word_q <= '0;
        end else begin
            case (state)
                DMA_IDLE: begin
                    if (cmd_valid) begin
                        is_write  <= cmd_write;
                        cur_addr  <= cmd_addr;
                        remaining <= cmd_len;
                    end
                end
                DMA_FILL: begin
                    if (wr_valid) wr_word_q <= wr_data;
                end
                DMA_WAIT: begin
                    if (mem.mem_done) begin
                        if (is_write) begin
                            cur_addr  <= cur_addr + ADDR_WIDTH'(1);
                            remaining <= remaining - LEN_WIDTH'(1);
                        end else begin
                            rd_word_q <= mem.mem_data_out;
                        end
                    end
                end
                DMA_DRAIN: begin
                    if (rd_ready) begin
                        cur_addr  <= cur_addr + ADDR_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SDRAM_TILE_DMA_CHECKSUM_EN
    // Running sum of the words that actually changed hands on either stream;
    // it stops moving once the command ends and holds until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_checksum <= '0;
        end else if (state == DMA_IDLE && cmd_valid) begin
            xfer_checksum <= '0;
        end else if (state == DMA_DRAIN && rd_ready) begin
            xfer_checksum <= xfer_checksum + rd_word_q;
        end else if (state == DMA_FILL && wr_valid) begin
            xfer_checksum <= xfer_checksum + wr_data;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_tile_dma.sv
// -----------------------------------------------------------------------------
// tb_sdram_tile_dma
// Bench for sdram_tile_dma: a behavioural access-FSM responder backed by an
// associative memory, a table of directed commands, a reset-in-flight
// sequence and a randomized command phase. Expected results come from the
// command itself: word i lives at base+i (mod 2^24), read data is what was
// preloaded there, write data is what was offered on the stream.
// Build with +define+SDRAM_TILE_DMA_CHECKSUM_EN to exercise xfer_checksum.
// -----------------------------------------------------------------------------
module tb_sdram_tile_dma;
    import sdram_pkg::*;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          busy, xfer_done;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] wr_data;
    logic          wr_valid, wr_ready;
`ifdef SDRAM_TILE_DMA_CHECKSUM_EN
    logic [DW-1:0] xfer_checksum;
`endif

    always #5 clk = ~clk;

    sdram_tile_dma_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    sdram_tile_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .busy          (busy),
        .xfer_done     (xfer_done),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
`ifdef SDRAM_TILE_DMA_CHECKSUM_EN
        .xfer_checksum (xfer_checksum),
`endif
        .mem           (mem_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- shared bench state ----------------
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    logic [DW-1:0] stim_words [$];
    logic [AW-1:0] start_addr_q [$];
    logic [DW-1:0] start_data_q [$];
    bit            start_wr_q [$];
    logic [DW-1:0] rd_q [$];
    int            wr_taken = 0;
    int            done_cnt = 0;
    int            lat_cfg  = 1;
    bit            spurious_en = 1'b0;

    // ---------------- access-FSM responder ----------------
    initial begin
        bit            pending = 1'b0;
        int            wait_cnt = 0;
        logic [AW-1:0] pend_addr;
        logic [DW-1:0] pend_data;
        bit            pend_wr;
        mem_if.mem_done     = 1'b0;
        mem_if.mem_data_out = '0;
        forever begin
            @(posedge clk); #2;
            mem_if.mem_done = 1'b0;
            if (!rst_n) begin
                pending = 1'b0;
            end else if (pending) begin
                check("no_start_in_wait", {31'b0, mem_if.mem_start_read | mem_if.mem_start_write}, 0);
                wait_cnt--;
                if (wait_cnt == 0) begin
                    check("mem_addr_hold", mem_if.mem_addr, pend_addr);
                    if (pend_wr) begin
                        check("mem_data_in_hold", mem_if.mem_data_in, pend_data);
                        mem_model[pend_addr] = pend_data;
                    end else begin
                        mem_if.mem_data_out = mem_model.exists(pend_addr) ? mem_model[pend_addr] : '0;
                    end
                    mem_if.mem_done = 1'b1;
                    pending = 1'b0;
                end
            end else if (mem_if.mem_start_read || mem_if.mem_start_write) begin
                check("start_exclusive", {31'b0, mem_if.mem_start_read & mem_if.mem_start_write}, 0);
                pending   = 1'b1;
                pend_addr = mem_if.mem_addr;
                pend_data = mem_if.mem_data_in;
                pend_wr   = mem_if.mem_start_write;
                wait_cnt  = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 5));
                start_addr_q.push_back(pend_addr);
                start_data_q.push_back(pend_data);
                start_wr_q.push_back(pend_wr);
            end else if (spurious_en && $urandom_range(0, 7) == 0) begin
                // Stray completion while no access is outstanding.
                mem_if.mem_data_out = DW'($urandom);
                mem_if.mem_done     = 1'b1;
            end
        end
    end

    // ---------------- stream / status monitor ----------------
    initial begin
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (xfer_done) done_cnt++;
                if (rd_valid && rd_ready) rd_q.push_back(rd_data);
                if (wr_valid && wr_ready) wr_taken++;
                if (prev_stall) begin
                    check("rd_valid_hold", {31'b0, rd_valid}, 1);
                    check("rd_data_hold", rd_data, prev_data);
                end
                if (rd_valid)
                    check("no_start_in_drain", {31'b0, mem_if.mem_start_read | mem_if.mem_start_write}, 0);
                check("busy_vs_ready", {31'b0, busy}, {31'b0, !cmd_ready});
                prev_stall = rd_valid && !rd_ready;
                prev_data  = rd_data;
            end
        end
    end

    // ---------------- one command against the reference model ----------------
    task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input int len,
                           input int rd_mode, input int gap, input int lat,
                           output logic [DW-1:0] sum_obs, output int n_starts,
                           output logic [AW-1:0] last_addr, output int done_cyc);
        logic [AW-1:0] exp_addr [$];
        logic [DW-1:0] model_sum = '0;
        int            pat [4] = '{1, 0, 0, 1};
        int            cyc = 0, last_idx = -1, gap_left = 0, done0, idx;
        bit            finished = 1'b0;

        for (int i = 0; i < len; i++) begin
            exp_addr.push_back(addr + AW'(i));
            model_sum += stim_words[i];
            mem_model[exp_addr[i]] = wr ? 16'hDEAD : stim_words[i];
        end
        lat_cfg = lat;
        rd_q.delete(); start_addr_q.delete(); start_data_q.delete(); start_wr_q.delete();
        wr_taken = 0;
        done0    = done_cnt;
        done_cyc = 0;

        check("cmd_ready_idle", {31'b0, cmd_ready}, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = LW'(len);

        while (!finished && cyc < 2000) begin
            @(posedge clk); #2;
            cyc++;
            if (cyc == 1) check("busy_after_accept", {31'b0, busy}, 1);
            if (xfer_done) begin
                finished  = 1'b1;
                done_cyc  = cyc;
                cmd_valid = 1'b0;
                check("ready_low_in_done", {31'b0, cmd_ready}, 0);
            end else begin
                // Commands offered while busy must be ignored.
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_write = 1'($urandom_range(0, 1));
                cmd_addr  = AW'($urandom);
                cmd_len   = LW'($urandom);
            end
            case (rd_mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = 1'($urandom_range(0, 1));
                default: rd_ready = (pat[cyc % 4] != 0);
            endcase
            if (wr) begin
                idx = wr_taken;
                if (idx != last_idx) begin
                    last_idx = idx;
                    gap_left = (gap >= 0) ? gap : int'($urandom_range(0, 3));
                end
                if (gap_left > 0) begin
                    gap_left--;
                    wr_valid = 1'b0;
                    wr_data  = DW'($urandom);
                end else begin
                    wr_valid = (idx < len);
                    wr_data  = (idx < len) ? stim_words[idx] : DW'($urandom);
                end
            end
        end
        rd_ready = 1'b0; wr_valid = 1'b0; cmd_valid = 1'b0;

        if (!finished) begin
            check("xfer_timeout", 0, 1);
            rst_n = 1'b0;
            @(posedge clk); #2;
            rst_n = 1'b1;
        end else begin
            @(posedge clk); #2;
            check("ready_after_done", {31'b0, cmd_ready}, 1);
            check("idle_after_done", {31'b0, busy}, 0);
            check("done_single_pulse", {31'b0, xfer_done}, 0);
        end

        check("done_count", done_cnt - done0, 1);
        n_starts = start_addr_q.size();
        check("start_count", n_starts, len);
        for (int i = 0; i < len && i < n_starts; i++) begin
            check("start_addr", start_addr_q[i], exp_addr[i]);
            check("start_dir", {31'b0, start_wr_q[i]}, {31'b0, wr});
            if (wr) check("start_wdata", start_data_q[i], stim_words[i]);
        end
        if (wr) begin
            check("wr_accepted", wr_taken, len);
            for (int i = 0; i < len; i++) check("mem_written", mem_model[exp_addr[i]], stim_words[i]);
        end else begin
            check("rd_count", rd_q.size(), len);
            for (int i = 0; i < len && i < rd_q.size(); i++) check("rd_data", rd_q[i], stim_words[i]);
        end
`ifdef SDRAM_TILE_DMA_CHECKSUM_EN
        check("xfer_checksum", xfer_checksum, model_sum);
        sum_obs = xfer_checksum;
`else
        sum_obs = '0;
        if (wr) foreach (start_data_q[i]) sum_obs += start_data_q[i];
        else    foreach (rd_q[i])         sum_obs += rd_q[i];
`endif
        last_addr = (n_starts > 0) ? start_addr_q[n_starts - 1] : '0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit                 wr;
        logic [AW-1:0]      addr;
        int                 len;
        logic [3:0][DW-1:0] w;
        int                 rd_mode;
        int                 gap;
        int                 lat;
        int                 exp_starts;
        logic [AW-1:0]      exp_last;
        logic [DW-1:0]      exp_sum;
        int                 exp_done_cyc;   // 0: latency not pinned
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [DW-1:0] sum_obs;
        logic [AW-1:0] last_addr;
        int            n_starts, done_cyc, done0;

        tbl[0] = '{wr:0, addr:24'h000100, len:4, w:{16'h4444, 16'h3333, 16'h2222, 16'h1111},
                   rd_mode:0, gap:0, lat:2, exp_starts:4, exp_last:24'h000103, exp_sum:16'hAAAA, exp_done_cyc:17};
        tbl[1] = '{wr:1, addr:24'h000200, len:3, w:{16'h0000, 16'h000C, 16'h000B, 16'h000A},
                   rd_mode:0, gap:2, lat:3, exp_starts:3, exp_last:24'h000202, exp_sum:16'h0021, exp_done_cyc:0};
        tbl[2] = '{wr:0, addr:24'h000300, len:4, w:{16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234},
                   rd_mode:2, gap:0, lat:1, exp_starts:4, exp_last:24'h000303, exp_sum:16'hE258, exp_done_cyc:0};
        tbl[3] = '{wr:0, addr:24'h000500, len:0, w:'0,
                   rd_mode:0, gap:0, lat:1, exp_starts:0, exp_last:24'h000000, exp_sum:16'h0000, exp_done_cyc:1};
        tbl[4] = '{wr:0, addr:24'hFFFFFE, len:3, w:{16'h0000, 16'hFFFF, 16'h0002, 16'h0001},
                   rd_mode:0, gap:0, lat:1, exp_starts:3, exp_last:24'h000000, exp_sum:16'h0002, exp_done_cyc:10};
        tbl[5] = '{wr:1, addr:24'hFFFFFF, len:2, w:{16'h0000, 16'h0000, 16'h8001, 16'h8000},
                   rd_mode:0, gap:0, lat:1, exp_starts:2, exp_last:24'h000000, exp_sum:16'h0001, exp_done_cyc:7};

        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        rd_ready  = 1'b0; wr_valid  = 1'b0; wr_data  = '0;

        // Asynchronous reset: outputs must settle before any clock edge.
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_cmd_ready", {31'b0, cmd_ready}, 1);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_xfer_done", {31'b0, xfer_done}, 0);
        check("rst_rd_valid", {31'b0, rd_valid}, 0);
        check("rst_wr_ready", {31'b0, wr_ready}, 0);
        check("rst_starts", {30'b0, mem_if.mem_start_read, mem_if.mem_start_write}, 0);
        check("rst_mem_addr", mem_if.mem_addr, 0);
        check("rst_mem_data_in", mem_if.mem_data_in, 0);
        check("rst_rd_data", rd_data, 0);
`ifdef SDRAM_TILE_DMA_CHECKSUM_EN
        check("rst_checksum", xfer_checksum, 0);
`endif
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        foreach (tbl[t]) begin
            stim_words.delete();
            for (int i = 0; i < tbl[t].len; i++) stim_words.push_back(tbl[t].w[i]);
            run_cmd(tbl[t].wr, tbl[t].addr, tbl[t].len, tbl[t].rd_mode, tbl[t].gap, tbl[t].lat,
                    sum_obs, n_starts, last_addr, done_cyc);
            check("tbl_starts", n_starts, tbl[t].exp_starts);
            check("tbl_sum", sum_obs, tbl[t].exp_sum);
            if (tbl[t].exp_starts > 0) check("tbl_last_addr", last_addr, tbl[t].exp_last);
            if (tbl[t].exp_done_cyc > 0) check("tbl_done_latency", done_cyc, tbl[t].exp_done_cyc);
        end

        // Reset while word 2 of a read is outstanding: no xfer_done, clean restart.
        stim_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        for (int i = 0; i < 4; i++) mem_model[24'h000400 + AW'(i)] = stim_words[i];
        lat_cfg = 4;
        start_addr_q.delete();
        done0 = done_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 24'h000400; cmd_len = 12'd4;
        rd_ready = 1'b1;
        begin
            int c = 0;
            @(posedge clk); #2;
            cmd_valid = 1'b0;
            while (start_addr_q.size() < 2 && c < 200) begin
                @(posedge clk); #2;
                c++;
            end
            check("reset_seq_second_start", {31'b0, start_addr_q.size() >= 2}, 1);
        end
        @(posedge clk); #3;
        check("pre_reset_busy", {31'b0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_cmd_ready", {31'b0, cmd_ready}, 1);
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_starts", {30'b0, mem_if.mem_start_read, mem_if.mem_start_write}, 0);
        check("midrst_mem_addr", mem_if.mem_addr, 0);
        check("midrst_rd_data", rd_data, 0);
        check("midrst_rd_valid", {31'b0, rd_valid}, 0);
        rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("no_done_after_reset", done_cnt - done0, 0);
        check("idle_after_reset", {31'b0, cmd_ready}, 1);
        run_cmd(1'b0, 24'h000400, 4, 0, 0, 2, sum_obs, n_starts, last_addr, done_cyc);
        check("post_reset_sum", sum_obs, 16'hAAAA);

        // Randomized commands, stray mem_done pulses while no access is pending.
        spurious_en = 1'b1;
        for (int k = 0; k < 14; k++) begin
            bit            wr = 1'($urandom_range(0, 1));
            logic [AW-1:0] addr;
            int            len = $urandom_range(0, 8);
            addr = ($urandom_range(0, 3) == 0) ? (24'hFFFFFF - AW'($urandom_range(0, 4))) : AW'($urandom);
            stim_words.delete();
            for (int i = 0; i < len; i++) stim_words.push_back(DW'($urandom));
            run_cmd(wr, addr, len, $urandom_range(0, 2), -1, 0, sum_obs, n_starts, last_addr, done_cyc);
        end
        spurious_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
